// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI byte-stream command decoder driving an auto-incrementing 8-bit register bank.
// Frames start with a command byte (bit7 = write, low bits = start address).
module spi_reg_bank #(
  parameter int NREGS = 8,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  input  logic                       cs_active,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic [7:0]                 tx_data,
  output logic [NREGS*8-1:0]         reg_out,
  output logic                       wr_stb,
  output logic [$clog2(NREGS)-1:0]   wr_addr,
  output logic [7:0]                 frame_bytes
);
  localparam int AW = $clog2(NREGS);
  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, rd_addr, wr_addr_q, wr_addr_d;
  logic [7:0] regs_q [NREGS];
  logic [7:0] tx_q, tx_d, fb_q, fb_d;
  logic wr_stb_q, wr_stb_d, we, load, acc;
  assign acc = cs_active && rx_valid && state_q != IDLE;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    rd_addr = ptr_q;
    wr_stb_d = 1'b0;
    wr_addr_d = wr_addr_q;
    we = 1'b0;
    load = 1'b0;
    fb_d = (acc && fb_q != 8'hFF) ? fb_q + 8'd1 : fb_q;
    if (!cs_active) state_d = IDLE;
    else case (state_q)
      IDLE: begin
        state_d = CMD;
        fb_d = '0;
      end
      CMD: if (rx_valid) begin
        state_d = rx_data[7] ? WRITE : READ;
        rd_addr = rx_data[AW-1:0];
        ptr_d = rx_data[7] ? rx_data[AW-1:0] : rx_data[AW-1:0] + 1'b1;
        load = !rx_data[7];
      end
      WRITE: if (rx_valid) begin
        we = 1'b1;
        wr_stb_d = 1'b1;
        wr_addr_d = ptr_q;
        ptr_d = ptr_q + 1'b1;
      end
      READ: if (rx_valid) begin
        load = 1'b1;
        ptr_d = ptr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Sync marker everywhere except while streaming read data
    tx_d = state_d != READ ? 8'hA5 : load ? regs_q[rd_addr] : tx_q;
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      ptr_q <= '0;
      tx_q <= 8'hA5;
      fb_q <= '0;
      wr_stb_q <= 1'b0;
      wr_addr_q <= '0;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= RESET_VAL;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      tx_q <= tx_d;
      fb_q <= fb_d;
      wr_stb_q <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      if (we) regs_q[ptr_q] <= rx_data;
    end
  end
  for (genvar i = 0; i < NREGS; i++) begin : g_out
    assign reg_out[8*i +: 8] = regs_q[i];
  end
  assign tx_data = tx_q;
  assign wr_stb = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign frame_bytes = fb_q;
endmodule
